seq_divu: RTL and testbench

SEQ_DIVU -- requirements
Module: seq_divu

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 21 ++
 rtl/seq_divu.sv | 113 +++++++++++
 tb/tb_seq_divu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH:0]   i_pr,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH:0]   o_pr,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_dsr_ext;

  assign w_shift   = {i_pr, i_bit};
  assign w_dsr_ext = {2'b00, i_dsr};
  assign o_qbit    = (w_shift >= w_dsr_ext);
  // The partial remainder stays below the divisor, so the difference always fits WIDTH+1 bits.
  assign o_pr      = o_qbit ? (WIDTH+1)'(w_shift - w_dsr_ext) : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_divu.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first,
// with valid/ready handshakes on both sides and a synchronous abort.
//
// state | meaning
// IDLE  | waiting for an operation; in_ready=1
// CALC  | iterating div_step, WIDTH cycles
// DONE  | result presented; out_valid=1 until out_ready
module seq_divu #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  import div_pkg::*;

  localparam int              CNT_W     = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH:0]   r_pr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH:0]   w_pr_nxt;
  logic             w_qbit;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_dsr_zero;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign quotient   = r_quot;
  assign remainder  = r_rem;
  assign div_zero   = r_dz;

  assign w_dsr_zero = (divisor == '0);
  assign w_accept   = in_ready & in_valid & ~abort;
  assign w_step     = (r_state == CALC) & ~abort;
  assign w_last     = w_step & (r_cnt == LAST_STEP);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_pr   (r_pr),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dsr  (r_dsr),
    .o_pr   (w_pr_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_dsr_zero ? DONE : CALC;
      CALC:    if (r_cnt == LAST_STEP) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // r_dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_pr   <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= dividend;
      r_dsr <= divisor;
      r_pr  <= '0;
      r_cnt <= '0;
      if (w_dsr_zero) begin
        r_quot <= '1;
        r_rem  <= dividend;
        r_dz   <= 1'b1;
      end
    end else if (w_step) begin
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
      r_pr  <= w_pr_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot <= {r_dvd[WIDTH-2:0], w_qbit};
        r_rem  <= w_pr_nxt[WIDTH-1:0];
        r_dz   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divu.sv
// Directed and randomized self-checking bench for seq_divu at WIDTH=7 and WIDTH=16.
module tb_seq_divu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        out_ready;
  logic [15:0] dvd;
  logic [15:0] dsr;
  logic        iv7, iv16;
  logic        ir7, ov7, dz7;
  logic [6:0]  q7, r7;
  logic        ir16, ov16, dz16;
  logic [15:0] q16, r16;

  logic        sel16;
  logic        m_ir, m_ov, m_dz;
  logic [15:0] m_q, m_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divu #(.WIDTH(7)) u7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv7), .in_ready(ir7),
    .dividend(dvd[6:0]), .divisor(dsr[6:0]), .abort(abort),
    .out_valid(ov7), .out_ready(out_ready), .quotient(q7),
    .remainder(r7), .div_zero(dz7)
  );

  seq_divu #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .dividend(dvd), .divisor(dsr), .abort(abort),
    .out_valid(ov16), .out_ready(out_ready), .quotient(q16),
    .remainder(r16), .div_zero(dz16)
  );

  always_comb begin
    m_ir = sel16 ? ir16 : ir7;
    m_ov = sel16 ? ov16 : ov7;
    m_dz = sel16 ? dz16 : dz7;
    m_q  = sel16 ? q16 : {9'd0, q7};
    m_r  = sel16 ? r16 : {9'd0, r7};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation to the WIDTH=7 instance and wait for out_valid.
  // lat counts edges after the acceptance edge until out_valid is seen high.
  task automatic run_op(input string tag, input int a, input int b, input int exp_lat,
                        input int exp_q, input int exp_r, input int exp_dz);
    int lat;
    chk({tag, "_ready"}, 32'(ir7), 32'd1);
    dvd = 16'(a);
    dsr = 16'(b);
    iv7 = 1'b1;
    tick();
    iv7 = 1'b0;
    dvd = 16'($urandom);
    dsr = 16'($urandom);
    lat = 0;
    while (ov7 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"},   32'(q7),  32'(exp_q));
    chk({tag, "_r"},   32'(r7),  32'(exp_r));
    chk({tag, "_dz"},  32'(dz7), 32'(exp_dz));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_ov"}, 32'(ov7), 32'd0);
    chk({tag, "_ir"}, 32'(ir7), 32'd1);
    out_ready = 1'b0;
  endtask

  // Back-to-back random operations with in_valid held high and random out_ready.
  task automatic rand_run(input bit wide, input int n_ops);
    int w, mask, done, cyc, acc_cyc, stalls, budget, a, b, ea, eb, sel;
    bit have_prev, prev_dz;
    w = wide ? 16 : 7;
    mask = (1 << w) - 1;
    sel16 = wide;
    out_ready = 1'b0;
    done = 0; cyc = 0; acc_cyc = 0; stalls = 0; ea = 0; eb = 1;
    have_prev = 1'b0; prev_dz = 1'b0;
    budget = n_ops * (w + 2) * 4 + 100;
    tick();
    while (done < n_ops && cyc < budget) begin
      sel = int'($urandom_range(0, 15));
      a = int'($urandom) & mask;
      if (sel == 15) a = mask;
      if (sel == 0) b = 0;
      else if (sel < 4) b = int'($urandom_range(1, 3));
      else begin
        b = int'($urandom) & mask;
        if (b == 0) b = 1;
      end
      dvd = 16'(a);
      dsr = 16'(b);
      if (wide) iv16 = 1'b1; else iv7 = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      if (m_ir) begin
        if (have_prev) chk("rand_ii", 32'(cyc - acc_cyc), 32'((prev_dz ? 2 : w + 2) + stalls));
        have_prev = 1'b1;
        acc_cyc = cyc;
        stalls = 0;
        ea = a;
        eb = b;
        prev_dz = (b == 0);
      end
      if (m_ov) begin
        if (out_ready) begin
          if (eb == 0) begin
            chk("rand_dz_q",  32'(m_q),  32'(mask));
            chk("rand_dz_r",  32'(m_r),  32'(ea));
            chk("rand_dz_dz", 32'(m_dz), 32'd1);
          end else begin
            chk("rand_q",     32'(m_q),  32'(ea / eb));
            chk("rand_r",     32'(m_r),  32'(ea % eb));
            chk("rand_ident", 32'(int'(m_q) * eb + int'(m_r)), 32'(ea));
            chk("rand_rlt",   32'((int'(m_r) < eb) ? 1 : 0), 32'd1);
            chk("rand_dz",    32'(m_dz), 32'd0);
          end
          done++;
        end else begin
          stalls++;
        end
      end
      tick();
      cyc++;
    end
    iv7 = 1'b0;
    iv16 = 1'b0;
    out_ready = 1'b0;
    chk(wide ? "rand16_done" : "rand7_done", 32'(done), 32'(n_ops));
  endtask

  initial begin
    int seen;
    rst_n = 1'b1; abort = 1'b0; out_ready = 1'b0;
    iv7 = 1'b0; iv16 = 1'b0; dvd = '0; dsr = '0; sel16 = 1'b0;

    // Reset takes effect before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ir",   32'(ir7),  32'd1);
    chk("rst_ov",   32'(ov7),  32'd0);
    chk("rst_q",    32'(q7),   32'd0);
    chk("rst_r",    32'(r7),   32'd0);
    chk("rst_dz",   32'(dz7),  32'd0);
    chk("rst_ir16", 32'(ir16), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("d100_7", 100, 7, 7, 14, 2, 0);     handshake("hs100_7");
    run_op("d5_9", 5, 9, 7, 0, 5, 0);          handshake("hs5_9");
    run_op("d127_1", 127, 1, 7, 127, 0, 0);    handshake("hs127_1");
    run_op("d127_127", 127, 127, 7, 1, 0, 0);  handshake("hs127_127");
    // Divide-by-zero: DONE is entered directly, out_valid visible in the first cycle after acceptance.
    run_op("d45_0", 45, 0, 0, 127, 45, 1);     handshake("hs45_0");

    // out_ready already high before DONE: out_valid lasts one cycle.
    out_ready = 1'b1;
    run_op("pre_rdy", 50, 3, 7, 16, 2, 0);
    tick();
    chk("pre_rdy_pulse", 32'(ov7), 32'd0);
    chk("pre_rdy_ir",    32'(ir7), 32'd1);
    out_ready = 1'b0;

    // Backpressure: result held for 10 cycles.
    run_op("bp", 93, 10, 7, 9, 3, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ov", 32'(ov7), 32'd1);
      chk("bp_ir", 32'(ir7), 32'd0);
      chk("bp_q",  32'(q7),  32'd9);
      chk("bp_r",  32'(r7),  32'd3);
    end
    handshake("bp_hs");

    // Abort in the third CALC cycle.
    dvd = 16'd100; dsr = 16'd7; iv7 = 1'b1;
    tick();
    iv7 = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ir", 32'(ir7), 32'd1);
    chk("abort_ov", 32'(ov7), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov7 !== 1'b0) seen++;
    end
    chk("abort_no_ov", 32'(seen), 32'd0);

    // Abort beats acceptance on the same edge.
    dvd = 16'd20; dsr = 16'd3; iv7 = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; iv7 = 1'b0;
    chk("abort_acc_ir", 32'(ir7), 32'd1);
    run_op("post_abort", 20, 3, 7, 6, 2, 0);   handshake("hs_post_abort");

    // Reset mid-CALC clears outputs without a clock edge.
    dvd = 16'd100; dsr = 16'd7; iv7 = 1'b1;
    tick();
    iv7 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ir", 32'(ir7), 32'd1);
    chk("mrst_ov", 32'(ov7), 32'd0);
    chk("mrst_q",  32'(q7),  32'd0);
    chk("mrst_r",  32'(r7),  32'd0);
    chk("mrst_dz", 32'(dz7), 32'd0);
    tick();
    chk("mrst_hold_ov", 32'(ov7), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 127, 127, 7, 1, 0, 0);  handshake("hs_post_rst");

    rand_run(1'b0, 1200);
    rand_run(1'b1, 1200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
